// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types and geometry helpers for the input-buffer read side.
package ibuf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Tag carried alongside each read through the latency shift and the FIFO.
    typedef struct packed {
        logic [7:0]  ky;
        logic [27:0] col;
        logic        last;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    function automatic int unsigned calc_bufw(input int unsigned pox,
                                              input int unsigned stride,
                                              input int unsigned ksize);
        return pox * stride + ksize / 2;
    endfunction

    function automatic int unsigned calc_rdepth(input int unsigned stride);
        return 2 * stride + 1;
    endfunction

    // x mod m by binary compare-and-subtract of shifted multiples of m.
    function automatic logic [7:0] mod_csub(input logic [8:0] x, input logic [7:0] m);
        logic [16:0] r;
        logic [16:0] ms;
        r = {8'd0, x};
        for (int unsigned i = 0; i < 9; i++) begin
            ms = {9'd0, m} << (8 - i);
            if (r >= ms) begin
                r = r - ms;
            end
        end
        return 8'(r);
    endfunction

endpackage

// File: rtl/ibuf_rd_fifo.sv
// ibuf_rd_fifo: first-word-fall-through FIFO on registered storage with occupancy count.
module ibuf_rd_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_en = pop && (cnt != '0);
    assign wr_en = push && ((cnt != CW'(DEPTH)) || rd_en);

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

    // Storage write; cleared on reset so the head word reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ibuf_reader.sv
// ibuf_reader: sweeps KSIZE rows x BUFW columns of the input buffer and streams
// the POY-lane words out over valid/ready. Define IBUF_READER_SVA_EN to compile
// in protocol assertions; behaviour is identical either way.
module ibuf_reader
    import ibuf_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned POY    = 3,
    parameter int unsigned POX    = 3,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        row_base,
    output logic              busy,
    output logic              done,
    output logic              ren,
    output logic [7:0]        rrow,
    output logic [27:0]       rcol,
    input  logic [POY*DW-1:0] rdata,
    output logic              ovalid,
    input  logic              oready,
    output logic [POY*DW-1:0] odata,
    output logic [7:0]        oky,
    output logic [27:0]       ocol,
    output logic              olast
);

    localparam int unsigned BUFW   = calc_bufw(POX, STRIDE, KSIZE);
    localparam int unsigned RDEPTH = calc_rdepth(STRIDE);
    localparam int unsigned FDEPTH = RD_LAT + 2;
    localparam int unsigned FW     = POY * DW + TAG_W;
    localparam int unsigned CW     = $clog2(FDEPTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       row_base_q;
    logic [7:0]       ky_q;
    logic [27:0]      col_q;
    logic             accept;
    logic             last_addr;
    logic             vld_sr [RD_LAT];
    tag_t             tag_sr [RD_LAT];
    logic [7:0]       inflight;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_rdata;
    tag_t             out_tag;
    logic             pop;
    logic             done_q;

    assign accept    = start && (state_q == IDLE);
    assign last_addr = (ky_q == 8'(KSIZE - 1)) && (col_q == 28'(BUFW - 1));
    assign ren       = (state_q == RUN) && ((32'(inflight) + 32'(fifo_count)) < FDEPTH);
    assign rrow      = mod_csub({1'b0, row_base_q} + {1'b0, ky_q}, 8'(RDEPTH));
    assign rcol      = col_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    assign ovalid  = !fifo_empty;
    assign out_tag = tag_t'(fifo_rdata[TAG_W-1:0]);
    assign odata   = fifo_rdata[FW-1:TAG_W];
    assign oky     = out_tag.ky;
    assign ocol    = out_tag.col;
    assign olast   = out_tag.last;
    assign pop     = ovalid && oready;

    // Reads issued but not yet returned.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 8'(vld_sr[i]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: leave RUN once the final read issues, finish on the last beat's handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (ren && last_addr) state_d = DRAIN;
            DRAIN:   if (pop && olast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch row_base and step (ky, col) on each issued read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base_q <= '0;
            ky_q       <= '0;
            col_q      <= '0;
        end else if (accept) begin
            row_base_q <= row_base;
            ky_q       <= '0;
            col_q      <= '0;
        end else if (ren) begin
            if (col_q == 28'(BUFW - 1)) begin
                col_q <= '0;
                ky_q  <= (ky_q == 8'(KSIZE - 1)) ? '0 : ky_q + 8'd1;
            end else begin
                col_q <= col_q + 28'd1;
            end
        end
    end

    // Latency shift pairing each read with its tag until rdata arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_sr[i] <= 1'b0;
                tag_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= ren;
            tag_sr[0] <= '{ky: ky_q, col: col_q, last: last_addr};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // One-cycle done in the cycle after the final beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state_q == DRAIN) && pop && olast;
    end

    ibuf_rd_fifo #(
        .DEPTH (FDEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_sr[RD_LAT-1]),
        .wdata ({rdata, tag_sr[RD_LAT-1]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef IBUF_READER_SVA_EN
    logic [15:0] beat_cnt;

    // Beats taken so far in the current pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         beat_cnt <= '0;
        else if (accept) beat_cnt <= '0;
        else if (pop)    beat_cnt <= beat_cnt + 16'd1;
    end

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ren |-> ((32'(inflight) + 32'(fifo_count)) < FDEPTH));
    a_no_ovf: assert property (@(posedge clk) disable iff (rst)
        32'(fifo_count) <= FDEPTH);
    a_no_ovf_push: assert property (@(posedge clk) disable iff (rst)
        (vld_sr[RD_LAT-1] && !pop) |-> (32'(fifo_count) < FDEPTH));
    a_no_unf: assert property (@(posedge clk) disable iff (rst)
        ovalid |-> (fifo_count != '0));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (ovalid && !oready) |=> (ovalid && $stable({odata, oky, ocol, olast})));
    a_done_1cyc: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);
    a_beats: assert property (@(posedge clk) disable iff (rst)
        ((state_q == DRAIN) && pop && olast) |-> (beat_cnt == 16'(KSIZE * BUFW - 1)));
`endif

endmodule

// File: tb/tb_ibuf_reader.sv
// tb_ibuf_reader: directed + randomized passes against a pass-level model of
// the read sweep (row/column order, modulo row wrap, data from a buffer model).
`timescale 1ns/1ps
module tb_ibuf_reader;

    localparam int unsigned DW     = 32;
    localparam int unsigned POY    = 3;
    localparam int unsigned POX    = 3;
    localparam int unsigned KSIZE  = 3;
    localparam int unsigned STRIDE = 1;
    localparam int unsigned BW     = POX * STRIDE + KSIZE / 2;
    localparam int unsigned RD     = 2 * STRIDE + 1;
    localparam int unsigned NB     = KSIZE * BW;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  row;
        logic [27:0] col;
    } rd_t;

    typedef struct {
        int unsigned     cyc;
        logic [95:0]     data;
        logic [7:0]      ky;
        logic [27:0]     col;
        logic            last;
    } bt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_w  [2];
    logic [7:0]  rb_w     [2];
    logic        busy_w   [2];
    logic        done_w   [2];
    logic        ren_w    [2];
    logic [7:0]  rrow_w   [2];
    logic [27:0] rcol_w   [2];
    logic [95:0] rdata_w  [2];
    logic        ovalid_w [2];
    logic        oready_w [2];
    logic [95:0] odata_w  [2];
    logic [7:0]  oky_w    [2];
    logic [27:0] ocol_w   [2];
    logic        olast_w  [2];

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned hold_err = 0;
    int unsigned credit_err = 0;
    int unsigned n_iss [2];
    int unsigned n_pop [2];
    logic [31:0] seed  [2];
    rd_t         reads [$];
    bt_t         beats [$];
    int unsigned done_cyc [$];
    logic        done_busy [$];

    logic        pv   [2][2];
    logic [7:0]  prow [2][2];
    logic [27:0] pcol [2][2];
    logic        hold_prev [2];
    logic [132:0] prev_out [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ibuf_reader #(.DW(DW), .STRIDE(STRIDE), .POY(POY), .POX(POX), .KSIZE(KSIZE), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .row_base(rb_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .ren(ren_w[0]), .rrow(rrow_w[0]), .rcol(rcol_w[0]), .rdata(rdata_w[0]),
        .ovalid(ovalid_w[0]), .oready(oready_w[0]), .odata(odata_w[0]), .oky(oky_w[0]),
        .ocol(ocol_w[0]), .olast(olast_w[0]));

    ibuf_reader #(.DW(DW), .STRIDE(STRIDE), .POY(POY), .POX(POX), .KSIZE(KSIZE), .RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .row_base(rb_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .ren(ren_w[1]), .rrow(rrow_w[1]), .rcol(rcol_w[1]), .rdata(rdata_w[1]),
        .ovalid(ovalid_w[1]), .oready(oready_w[1]), .odata(odata_w[1]), .oky(oky_w[1]),
        .ocol(ocol_w[1]), .olast(olast_w[1]));

    // Contents of buffer word (row, col): distinct per row, column, lane and pass seed.
    function automatic logic [95:0] mem_word(input logic [31:0] s, input int unsigned row,
                                             input int unsigned col);
        logic [95:0] w;
        for (int unsigned p = 0; p < POY; p++) begin
            w[p*DW +: DW] = s ^ (row * 32'h0100_0193) ^ (col * 32'h0009_E377)
                            ^ ((p + 1) * 32'h85EB_CA6B);
        end
        return w;
    endfunction

    // Buffer model and pass monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        for (int unsigned d = 0; d < 2; d++) begin
            if (pv[d][d]) rdata_w[d] = mem_word(seed[d], prow[d][d], pcol[d][d]);
            else          rdata_w[d] = {$urandom, $urandom, $urandom};
            pv[d][1] = pv[d][0]; prow[d][1] = prow[d][0]; pcol[d][1] = pcol[d][0];
            pv[d][0] = ren_w[d]; prow[d][0] = rrow_w[d]; pcol[d][0] = rcol_w[d];
            if (rst) begin
                hold_prev[d] = 1'b0;
            end else begin
                if (busy_w[d] && n_iss[d] < NB) begin
                    if (ren_w[d] !== ((n_iss[d] - n_pop[d]) < (d + 3))) credit_err++;
                end else if (ren_w[d] !== 1'b0) begin
                    credit_err++;
                end
                if (hold_prev[d] && (ovalid_w[d] !== 1'b1 ||
                    {odata_w[d], oky_w[d], ocol_w[d], olast_w[d]} !== prev_out[d])) hold_err++;
                hold_prev[d] = ovalid_w[d] && !oready_w[d];
                prev_out[d]  = {odata_w[d], oky_w[d], ocol_w[d], olast_w[d]};
                if (ren_w[d]) begin
                    reads.push_back('{cyc: cyc, row: rrow_w[d], col: rcol_w[d]});
                    n_iss[d]++;
                end
                if (ovalid_w[d] && oready_w[d]) begin
                    beats.push_back('{cyc: cyc, data: odata_w[d], ky: oky_w[d],
                                      col: ocol_w[d], last: olast_w[d]});
                    n_pop[d]++;
                end
                if (done_w[d]) begin
                    done_cyc.push_back(cyc);
                    done_busy.push_back(busy_w[d]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pass(input int unsigned d);
        reads.delete();
        beats.delete();
        done_cyc.delete();
        done_busy.delete();
        n_iss[d] = 0;
        n_pop[d] = 0;
        hold_err = 0;
        credit_err = 0;
        seed[d] = $urandom;
    endtask

    // mode 0: oready=1 with exact timing; 1: stall cycles 5-9 plus ignored restart; 2: random oready.
    task automatic do_pass(input int unsigned d, input int unsigned rb, input int unsigned mode);
        int unsigned t0;
        int unsigned rel;
        int unsigned lat;
        int unsigned row;
        lat = d + 1;
        clear_pass(d);
        t0 = cyc;
        start_w[d] = 1'b1;
        rb_w[d] = 8'(rb);
        oready_w[d] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mode == 0) chk("busy_c0", busy_w[d], 1'b0);
        rel = 0;
        while (done_cyc.size() == 0 && rel < 400) begin
            @(posedge clk); #1;
            rel++;
            start_w[d] = (mode == 1 && rel == 4);
            if (mode == 1 && rel == 4) rb_w[d] = 8'd1;
            if (mode == 2)      oready_w[d] = 1'($urandom_range(0, 1));
            else if (mode == 1) oready_w[d] = !(rel >= 5 && rel <= 9);
            else                oready_w[d] = 1'b1;
            if (mode == 0 && rel == 1) begin
                chk("busy_c1", busy_w[d], 1'b1);
                chk("ren_c1", ren_w[d], 1'b1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) begin
            chk("busy_at_done", done_busy[0], 1'b0);
            if (mode == 0) chk("done_cycle", done_cyc[0] - t0, NB + lat + 2);
        end
        chk("read_count", reads.size(), NB);
        chk("beat_count", beats.size(), NB);
        for (int unsigned i = 0; i < NB; i++) begin
            row = (rb + i / BW) % RD;
            if (i < reads.size()) begin
                chk($sformatf("read%0d_addr", i), {reads[i].row, reads[i].col},
                    {8'(row), 28'(i % BW)});
                if (mode == 0) chk($sformatf("read%0d_cyc", i), reads[i].cyc - t0, i + 1);
            end
            if (i < beats.size()) begin
                chk($sformatf("beat%0d_data", i), beats[i].data, mem_word(seed[d], row, i % BW));
                chk($sformatf("beat%0d_tag", i), {beats[i].ky, beats[i].col, beats[i].last},
                    {8'(i / BW), 28'(i % BW), (i == NB - 1)});
                if (mode == 0) chk($sformatf("beat%0d_cyc", i), beats[i].cyc - t0, i + lat + 2);
            end
        end
        chk("hold_err", hold_err, 0);
        chk("credit_err", credit_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int unsigned d = 0; d < 2; d++) begin
            start_w[d] = 1'b0; rb_w[d] = '0; oready_w[d] = 1'b1; seed[d] = '0;
            n_iss[d] = 0; n_pop[d] = 0; hold_prev[d] = 1'b0; prev_out[d] = '0;
            pv[d][0] = 1'b0; pv[d][1] = 1'b0;
            prow[d][0] = '0; prow[d][1] = '0; pcol[d][0] = '0; pcol[d][1] = '0;
            rdata_w[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy_w[0], done_w[0], ren_w[0], ovalid_w[0], olast_w[0],
                           rrow_w[0], rcol_w[0], oky_w[0], ocol_w[0]}, '0);
        chk("reset_odata", odata_w[0], '0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_pass(0, 0, 0);
        do_pass(0, 2, 1);

        // Reset in cycle 7 of a pass: outputs clear at once, no done follows.
        clear_pass(0);
        start_w[0] = 1'b1;
        rb_w[0] = 8'd0;
        oready_w[0] = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            start_w[0] = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {busy_w[0], done_w[0], ren_w[0], ovalid_w[0], olast_w[0],
                             rrow_w[0], rcol_w[0], oky_w[0], ocol_w[0]}, '0);
        chk("rst_mid_odata", odata_w[0], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_done", done_cyc.size(), 0);

        do_pass(0, 0, 0);
        for (int unsigned k = 0; k < 4; k++) begin
            do_pass(0, $urandom_range(0, 255), 2);
        end
        do_pass(1, 0, 0);
        do_pass(1, $urandom_range(0, 255), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
